// File: rtl/seq_slice_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor: one CHUNK-bit ripple slice per clock, LSB first,
// with a start/busy/done handshake, carry-out and signed-overflow flag.
module seq_slice_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    input  logic             C_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             C_out,
    output logic             ovf
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   op_a_q, op_a_d;
    logic [WIDTH-1:0]   op_b_q, op_b_d;
    logic               carry_q, carry_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   part_q, part_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               c_out_q, c_out_d;
    logic               ovf_q, ovf_d;

    logic               accept;
    logic               last_slice;
    logic [31:0]        base;
    logic [CHUNK-1:0]   slice_a, slice_b, slice_sum;
    logic               slice_cout;
    logic               ripple_c;

    // Start is honoured only when no operation is in flight.
    assign accept     = start && (state_q == IDLE || state_q == DONE);
    assign last_slice = (idx_q == IDX_W'(N - 1));
    assign base       = 32'(idx_q) * 32'(CHUNK);
    assign slice_a    = op_a_q[base +: CHUNK];
    assign slice_b    = op_b_q[base +: CHUNK];

    always_comb begin : ripple_chain
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        ripple_c  = carry_q;
        slice_sum = '0;
        for (int i = 0; i < CHUNK; i++) begin
            slice_sum[i] = slice_a[i] ^ slice_b[i] ^ ripple_c;
            ripple_c     = (slice_a[i] & slice_b[i]) | (ripple_c & (slice_a[i] ^ slice_b[i]));
        end
        slice_cout = ripple_c;
    end

    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_slice) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin : datapath_next
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        part_d  = part_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        if (accept) begin
            op_a_d  = A_in;
            op_b_d  = sub ? ~B_in : B_in;
            carry_d = sub | C_in;
            idx_d   = '0;
            part_d  = '0;
        end else if (state_q == RUN) begin
            part_d[base +: CHUNK] = slice_sum;
            carry_d = slice_cout;
            idx_d   = idx_q + 1'b1;
            if (last_slice) begin
                sum_d   = part_d;
                c_out_d = slice_cout;
                // ovf compares against the post-inversion opB, so subtraction is covered too.
                ovf_d   = (op_a_q[WIDTH-1] == op_b_q[WIDTH-1]) && (part_d[WIDTH-1] != op_a_q[WIDTH-1]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : state_reg
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin : datapath_reg
        if (!rst_n) begin
            op_a_q  <= '0;
            op_b_q  <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            part_q  <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            part_q  <= part_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin : outputs
        busy  = (state_q == RUN);
        done  = (state_q == DONE);
        sum   = sum_q;
        C_out = c_out_q;
        ovf   = ovf_q;
    end

endmodule

// File: tb/tb_seq_slice_adder.sv
// Directed bench for seq_slice_adder: default CHUNK=8 instance plus CHUNK=32 and CHUNK=1
// instances sharing operands and reset, each with its own start.
module tb_seq_slice_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sub;
    logic [31:0] a, b;
    logic        cin;
    logic        start_8, start_32, start_1;

    logic        busy_8, done_8, cout_8, ovf_8;
    logic        busy_32, done_32, cout_32, ovf_32;
    logic        busy_1, done_1, cout_1, ovf_1;
    logic [31:0] sum_8, sum_32, sum_1;

    int          sel;
    logic        m_busy, m_done, m_cout, m_ovf;
    logic [31:0] m_sum;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_slice_adder #(.WIDTH(32), .CHUNK(8)) u_dut_8 (
        .clk(clk), .rst_n(rst_n), .start(start_8), .sub(sub), .A_in(a), .B_in(b), .C_in(cin),
        .busy(busy_8), .done(done_8), .sum(sum_8), .C_out(cout_8), .ovf(ovf_8));

    seq_slice_adder #(.WIDTH(32), .CHUNK(32)) u_dut_32 (
        .clk(clk), .rst_n(rst_n), .start(start_32), .sub(sub), .A_in(a), .B_in(b), .C_in(cin),
        .busy(busy_32), .done(done_32), .sum(sum_32), .C_out(cout_32), .ovf(ovf_32));

    seq_slice_adder #(.WIDTH(32), .CHUNK(1)) u_dut_1 (
        .clk(clk), .rst_n(rst_n), .start(start_1), .sub(sub), .A_in(a), .B_in(b), .C_in(cin),
        .busy(busy_1), .done(done_1), .sum(sum_1), .C_out(cout_1), .ovf(ovf_1));

    always_comb begin
        m_busy = busy_8; m_done = done_8; m_sum = sum_8; m_cout = cout_8; m_ovf = ovf_8;
        if (sel == 1) begin
            m_busy = busy_32; m_done = done_32; m_sum = sum_32; m_cout = cout_32; m_ovf = ovf_32;
        end else if (sel == 2) begin
            m_busy = busy_1; m_done = done_1; m_sum = sum_1; m_cout = cout_1; m_ovf = ovf_1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_start(input logic v);
        start_8  = (sel == 0) ? v : 1'b0;
        start_32 = (sel == 1) ? v : 1'b0;
        start_1  = (sel == 2) ? v : 1'b0;
    endtask

    // Issues one operation on the selected instance, returns edges from start to done.
    task automatic run_op(input string tag, input logic s, input logic [31:0] av, input logic [31:0] bv,
                          input logic c, output int lat);
        @(negedge clk);
        a = av; b = bv; cin = c; sub = s;
        set_start(1'b1);
        @(posedge clk);
        @(negedge clk);
        set_start(1'b0);
        check({tag, " busy"}, 32'(m_busy), 32'd1);
        lat = 0;
        while (!m_done && lat < 100) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check({tag, " busy_with_done"}, 32'(m_busy), 32'd0);
    endtask

    task automatic op_check(input string tag, input logic s, input logic [31:0] av, input logic [31:0] bv,
                            input logic c, input int exp_lat, input logic [31:0] exp_sum,
                            input logic exp_c, input logic exp_ovf);
        int lat;
        run_op(tag, s, av, bv, c, lat);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " sum"}, m_sum, exp_sum);
        check({tag, " c_out"}, 32'(m_cout), 32'(exp_c));
        check({tag, " ovf"}, 32'(m_ovf), 32'(exp_ovf));
    endtask

    initial begin
        int lat;
        int done_seen;
        sel = 0;
        rst_n = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
        start_8 = 1'b0; start_32 = 1'b0; start_1 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("reset busy", 32'(busy_8), 32'd0);
        check("reset done", 32'(done_8), 32'd0);
        check("reset sum", sum_8, 32'd0);
        check("reset c_out", 32'(cout_8), 32'd0);
        check("reset ovf", 32'(ovf_8), 32'd0);

        op_check("add_20_9", 1'b0, 32'd20, 32'd9, 1'b0, 4, 32'd29, 1'b0, 1'b0);
        @(negedge clk);
        check("done_pulse_width", 32'(done_8), 32'd0);
        check("sum_held", sum_8, 32'd29);

        op_check("add_big", 1'b0, 32'd999999, 32'd29999999, 1'b0, 4, 32'd30999998, 1'b0, 1'b0);
        op_check("add_wrap", 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b1, 4, 32'd0, 1'b1, 1'b0);
        op_check("sub_5_7", 1'b1, 32'd5, 32'd7, 1'b1, 4, 32'hFFFF_FFFE, 1'b0, 1'b0);
        op_check("sub_7_5", 1'b1, 32'd7, 32'd5, 1'b0, 4, 32'd2, 1'b1, 1'b0);
        op_check("add_ovf", 1'b0, 32'h7FFF_FFFF, 32'd1, 1'b0, 4, 32'h8000_0000, 1'b0, 1'b1);
        op_check("sub_ovf", 1'b1, 32'h8000_0000, 32'd1, 1'b0, 4, 32'h7FFF_FFFF, 1'b1, 1'b1);

        // Start held through RUN with changing operands, then into DONE.
        @(negedge clk);
        a = 32'd1; b = 32'd2; cin = 1'b0; sub = 1'b0; start_8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a = 32'd100; b = 32'd200;
        lat = 0;
        while (!done_8 && lat < 100) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check("hold latency", 32'(lat), 32'd4);
        check("hold sum", sum_8, 32'd3);
        @(posedge clk);
        @(negedge clk);
        start_8 = 1'b0;
        check("b2b busy", 32'(busy_8), 32'd1);
        lat = 0;
        while (!done_8 && lat < 100) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check("b2b latency", 32'(lat), 32'd4);
        check("b2b sum", sum_8, 32'd300);

        // Reset asserted during the second RUN cycle.
        @(negedge clk);
        a = 32'd20; b = 32'd9; start_8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_8 = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst busy", 32'(busy_8), 32'd0);
        check("rst done", 32'(done_8), 32'd0);
        check("rst sum", sum_8, 32'd0);
        check("rst c_out", 32'(cout_8), 32'd0);
        check("rst ovf", 32'(ovf_8), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done_8 || busy_8) done_seen++;
        end
        check("no_done_after_rst", 32'(done_seen), 32'd0);

        sel = 1;
        op_check("chunk32", 1'b0, 32'd20, 32'd9, 1'b0, 1, 32'd29, 1'b0, 1'b0);
        op_check("chunk32 sub_ovf", 1'b1, 32'h8000_0000, 32'd1, 1'b0, 1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        sel = 2;
        op_check("chunk1", 1'b0, 32'd20, 32'd9, 1'b0, 32, 32'd29, 1'b0, 1'b0);
        op_check("chunk1 sub_ovf", 1'b1, 32'h8000_0000, 32'd1, 1'b0, 32, 32'h7FFF_FFFF, 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
